// File: rtl/imem_dump.sv
// Memory readback streamer: reads a range of 32-bit words from a synchronous-read
// memory port and emits them as a little-endian byte stream over valid/ready.
module imem_dump #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
    logic [31:0]           shreg, shreg_nxt;
    logic [1:0]            byte_idx, byte_idx_nxt;
    logic                  hs;

    assign hs = (state == S_SEND) && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            shreg     <= '0;
            byte_idx  <= '0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            remaining <= remaining_nxt;
            shreg     <= shreg_nxt;
            byte_idx  <= byte_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        shreg_nxt     = shreg;
        byte_idx_nxt  = byte_idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A zero-length request still reports completion, but touches nothing.
                    if (word_count != '0) begin
                        cur_addr_nxt  = base_addr;
                        remaining_nxt = word_count;
                        state_nxt     = S_READ;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                shreg_nxt    = mem_rdata;
                byte_idx_nxt = 2'd0;
                state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    shreg_nxt    = {8'h00, shreg[31:8]};
                    byte_idx_nxt = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (remaining == CNT_ONE) begin
                            state_nxt = S_DONE;
                        end else begin
                            cur_addr_nxt  = cur_addr + ADDR_ONE;
                            remaining_nxt = remaining - CNT_ONE;
                            state_nxt     = S_READ;
                        end
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte output comes straight off registered state, so it is stable while stalled.
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign mem_en   = (state == S_READ);
    assign mem_addr = cur_addr;
    assign tx_valid = (state == S_SEND);
    assign tx_data  = shreg[7:0];

endmodule

// File: doc/imem_dump.md
# imem_dump

Memory readback streamer for the single-stage RV core. When started, it reads a range of 32-bit words from a synchronous-read instruction/data memory port and emits them as a little-endian byte stream over a valid/ready interface. It is the inverse of the hex-image load path: it lets the bench or a host dump memory contents after a run and compare them against the loaded image.

## Interface
- ADDR_WIDTH, 10, word-address width of the memory port; the range is 2^ADDR_WIDTH words.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; latched on accepted start.
- word_count  in  ADDR_WIDTH+1  number of words to dump, 0..2^ADDR_WIDTH; latched on accepted start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the dump completes.
- mem_en  out  1  read strobe to the memory.
- mem_addr  out  ADDR_WIDTH  word address of the read.
- mem_rdata  in  32  read data, valid in the cycle after mem_en.
- tx_data  out  8  output byte.
- tx_valid  out  1  output byte is valid.
- tx_ready  in  1  sink accepts the byte; a handshake occurs when tx_valid & tx_ready.

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: if start=1 and word_count≠0, latch cur_addr=base_addr and remaining=word_count, then go to READ. If start=1 and word_count=0, go directly to DONE with no memory access and no bytes sent.
- READ: mem_en=1 and mem_addr=cur_addr for exactly one cycle, then go to WAIT.
- WAIT: load the 32-bit shift register from mem_rdata, set byte_idx=0, then go to SEND.
- SEND: tx_valid=1 and tx_data=shreg[7:0]. On each handshake, shift shreg right by 8 and increment byte_idx. On the handshake with byte_idx=3:
  - if remaining=1, go to DONE;
  - otherwise, cur_addr+=1 (wraps modulo 2^ADDR_WIDTH), remaining-=1, and go to READ.
- DONE: done=1 for one cycle, then go to IDLE.
- Byte order within a word: bits [7:0], [15:8], [23:16], [31:24].
- Once tx_valid is asserted, tx_valid and tx_data are held stable until the handshake. tx_valid never drops without a handshake, except on rst.
- start while busy is ignored, with no effect on the latched parameters.
- mem_en is 0 in every state except READ. mem_addr is don't-care when mem_en=0, but is driven as cur_addr.
- rst is asserted at any point, including mid-word: next state is IDLE, the partially sent word is abandoned, and no done pulse is generated.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, tx_valid=0, tx_data=0.
- Start is accepted in cycle 0.
- Cycle 1 is READ; cycle 2 is WAIT, with mem_rdata sampled.
- tx_valid first rises in cycle 3.
- With tx_ready held at 1:
  - each word takes 6 cycles (READ, WAIT, 4×SEND);
  - the last handshake of N words is in cycle 6N;
  - done pulses in cycle 6N+1;
  - busy is high in cycles 1..6N+1.
- Zero-count start: done pulses in cycle 1, and busy is high only in cycle 1.
- Backpressure stalls SEND only. The memory is never re-read for the same word.
- The next start can be accepted in the first IDLE cycle after DONE.

## Test plan
- Single word: mem[0]=32'h00a00093, base=0, count=1, tx_ready=1 → bytes 93,00,a0,00 handshake in cycles 3..6; done in cycle 7; mem_en high only in cycle 1.
- Three words, mem[4..6]=32'h00a00093/32'h01400113/32'hffb00193, base=4, count=3, tx_ready toggling 1-0 → 12 bytes in order 93 00 a0 00 13 01 40 01 93 01 b0 ff; tx_valid/tx_data are stable across every tx_ready=0 cycle; mem_addr sequence is 4,5,6.
- Zero count: start with count=0 → done in cycle 1, with no mem_en and no tx_valid.
- Wrap-around: ADDR_WIDTH=10, base=1023, count=2 → mem_addr sequence 1023 then 0, producing 8 bytes.
- Start while busy: second start with different base/count during SEND → ignored; the original dump completes unchanged, with exactly one done pulse.
- Reset mid-word: rst asserted after the 2nd byte handshake of word 0 → next cycle tx_valid=0, busy=0, no done; a fresh start then dumps from its own base correctly.
